// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage RV64M multiply/divide unit.
//   - mdu_op_e    : 4-bit M-extension op codes carried on op_i
//   - mdu_state_e : control FSM encodings
//   - is_div / is_rem / is_signed / is_src2_signed / is_word : op predicates
package ex_muldiv_unit_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    // src1 is treated as signed. MULW only keeps low product bits, so it
    // can run unsigned.
    function automatic logic is_signed(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                          OP_DIVW, OP_REMW};
    endfunction

    // MULHSU is the only op whose two operands differ in signedness.
    function automatic logic is_src2_signed(input logic [3:0] op);
        return is_signed(op) && (op != OP_MULHSU);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider datapath on unsigned magnitudes.
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : capture dividend/divisor and clear the partial remainder
//   dividend        : magnitude, MSB-aligned by the caller (W ops pre-shifted)
//   divisor         : magnitude
//   step            : retire one quotient bit this cycle
//   quotient_next   : quotient register value after this cycle's step
//   remainder_next  : remainder register value after this cycle's step
// The "_next" outputs let the owner register the final result on the same
// edge as the last step instead of spending an extra cycle.
module mdu_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            step,
    output logic [XLEN-1:0] quotient_next,
    output logic [XLEN-1:0] remainder_next
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   partial;
    logic            fits;

    // Shift the next dividend bit into the partial remainder and try the
    // subtraction; the extra top bit keeps the comparison exact.
    assign partial        = {rem_q, quo_q[XLEN-1]};
    assign fits           = partial >= {1'b0, dsr_q};
    assign remainder_next = fits ? (partial[XLEN-1:0] - dsr_q) : partial[XLEN-1:0];
    assign quotient_next  = {quo_q[XLEN-2:0], fits};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            rem_q <= remainder_next;
            quo_q <= quotient_next;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage.
//   clk, rst_n      : clock, synchronous active-low reset
//   valid_i, op_i   : M-extension op held by EX (stable while stall_req_o=1)
//   src1_i, src2_i  : rs1 / rs2 values
//   flush_i         : EX instruction killed, abort and return to IDLE
//   hold_i          : downstream stall, keeps a finished result presented
//   stall_req_o     : stall request to the hazard controller
//   result_valid_o  : result_o valid this cycle
//   result_o        : registered result with RISC-V M semantics
// Multiplies use a shift-add loop on magnitudes; divides use mdu_divider.
// Divide-by-zero and signed overflow bypass the loop and finish next cycle.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);

    mdu_state_e        state, state_nxt;
    logic [CW-1:0]     count;
    logic [3:0]        op_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic [2*XLEN-1:0] acc, mcand, acc_nxt;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   result_q;

    logic              accept, div_op, word_op, s1_en, s2_en;
    logic              sign1, sign2, div_zero, div_ovf, special;
    logic [XLEN-1:0]   mag1, mag2, div_dividend;
    logic [XLEN-1:0]   quo_nxt, rem_nxt;
    logic              div_step;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x);
        return {{(XLEN-WORD_W){x[WORD_W-1]}}, x[WORD_W-1:0]};
    endfunction

    // Magnitude of an operand at XLEN or word width; W results land in the
    // low 32 bits with zeros above (|-2^31| still fits unsigned).
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                  input logic neg,
                                                  input logic word);
        logic [XLEN-1:0] v;
        v = word ? {{(XLEN-WORD_W){1'b0}}, x[WORD_W-1:0]} : x;
        if (neg)
            v = word ? -sext_word(x) : -x;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] special_result(input logic [3:0] op,
                                                       input logic [XLEN-1:0] src1,
                                                       input logic dz,
                                                       input logic word);
        logic [XLEN-1:0] dvd;
        dvd = word ? sext_word(src1) : src1;
        if (is_rem(op))
            return dz ? dvd : '0;
        return dz ? '1 : dvd;
    endfunction

    function automatic logic [XLEN-1:0] final_result(input logic [3:0] op,
                                                     input logic [2*XLEN-1:0] prod,
                                                     input logic [XLEN-1:0] quo,
                                                     input logic [XLEN-1:0] rem,
                                                     input logic neg_res,
                                                     input logic neg_rem);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r, res;
        p = neg_res ? -prod : prod;
        q = neg_res ? -quo : quo;
        r = neg_rem ? -rem : rem;
        case (op)
            OP_MUL:                       res = p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = p[2*XLEN-1:XLEN];
            OP_MULW:                      res = sext_word(p[XLEN-1:0]);
            OP_DIV, OP_DIVU:              res = q;
            OP_REM, OP_REMU:              res = r;
            OP_DIVW, OP_DIVUW:            res = sext_word(q);
            OP_REMW, OP_REMUW:            res = sext_word(r);
            default:                      res = '0;
        endcase
        return res;
    endfunction

    // Decode of the op presented in IDLE
    assign accept   = (state == ST_IDLE) & valid_i & ~flush_i;
    assign div_op   = is_div(op_i);
    assign word_op  = is_word(op_i);
    assign s1_en    = is_signed(op_i);
    assign s2_en    = is_src2_signed(op_i);
    assign sign1    = s1_en & (word_op ? src1_i[WORD_W-1] : src1_i[XLEN-1]);
    assign sign2    = s2_en & (word_op ? src2_i[WORD_W-1] : src2_i[XLEN-1]);
    assign mag1     = magnitude(src1_i, sign1, word_op);
    assign mag2     = magnitude(src2_i, sign2, word_op);

    assign div_zero = div_op & (word_op ? (src2_i[WORD_W-1:0] == '0) : (src2_i == '0));
    assign div_ovf  = div_op & s1_en &
                      (word_op ? ((src1_i[WORD_W-1:0] == {1'b1, {(WORD_W-1){1'b0}}}) &&
                                  (src2_i[WORD_W-1:0] == '1))
                               : ((src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1)));
    assign special  = div_zero | div_ovf;

    // W dividends sit in the top half so 32 steps consume exactly their bits.
    assign div_dividend = word_op ? {mag1[WORD_W-1:0], {(XLEN-WORD_W){1'b0}}} : mag1;
    assign div_step     = (state == ST_BUSY) & ~flush_i;
    assign acc_nxt      = acc + (mplier[0] ? mcand : '0);

    mdu_divider #(.XLEN(XLEN)) u_divider (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (accept),
        .dividend       (div_dividend),
        .divisor        (mag2),
        .step           (div_step),
        .quotient_next  (quo_nxt),
        .remainder_next (rem_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (flush_i)
                    state_nxt = ST_IDLE;
                else if (count == CW'(1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: if (flush_i || !hold_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= op_i;
                        neg_res_q <= sign1 ^ sign2;
                        neg_rem_q <= sign1;
                        acc       <= '0;
                        mcand     <= {{XLEN{1'b0}}, mag1};
                        mplier    <= mag2;
                        if (special) begin
                            count    <= '0;
                            result_q <= special_result(op_i, src1_i, div_zero, word_op);
                        end else begin
                            count    <= word_op ? CW'(WORD_W) : CW'(XLEN);
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        count <= '0;
                    end else begin
                        count  <= count - CW'(1);
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        // Last step: fold sign fix-up and selection into the result register.
                        if (count == CW'(1))
                            result_q <= final_result(op_q, acc_nxt, quo_nxt, rem_nxt,
                                                     neg_res_q, neg_rem_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_req_o    = rst_n & valid_i & ~flush_i &
                            ((state == ST_IDLE) | (state == ST_BUSY));
    assign result_valid_o = (state == ST_DONE) & ~flush_i;
    assign result_o       = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  op_i = 4'd0;
    logic [63:0] src1_i = '0;
    logic [63:0] src2_i = '0;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        stall_req_o;
    logic        result_valid_o;
    logic [63:0] result_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .op_i           (op_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .flush_i        (flush_i),
        .hold_i         (hold_i),
        .stall_req_o    (stall_req_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    // While hold_i is high the same entry is re-checked (stability), and it
    // is retired on the cycle the pipeline takes it.
    initial forever begin
        @(negedge clk);
        if (rst_n && result_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got=%h required=none", result_o);
            end else begin
                check_eq(hold_i ? "result_held" : "result", result_o, exp_q[0]);
                if (!hold_i) void'(exp_q.pop_front());
            end
        end
    end

    // Issue one op at posedge+1 and follow it to its result cycle.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input int hold_cycles);
        int  k;
        int  stalls;
        bit  seen;
        exp_q.push_back(exp);
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        valid_i = 1'b1;
        hold_i  = (hold_cycles > 0);
        k = 0;
        stalls = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (result_valid_o) seen = 1'b1;
            else begin
                if (stall_req_o) stalls++;
                k++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=no_result required=result_at_%0d", name, lat);
            void'(exp_q.pop_back());
            valid_i = 1'b0;
            hold_i  = 1'b0;
            @(posedge clk); #1;
            return;
        end
        check_eq({name, "_latency"}, 64'(k), 64'(lat));
        check_eq({name, "_stall_cycles"}, 64'(stalls), 64'(lat));
        check_eq({name, "_stall_in_done"}, 64'(stall_req_o), 64'd0);
        for (int h = 1; h <= hold_cycles; h++) begin
            @(posedge clk); #1;
            if (h == hold_cycles) hold_i = 1'b0;
            @(negedge clk);
            check_eq({name, "_hold_valid"}, 64'(result_valid_o), 64'd1);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        if (hold_cycles > 0) begin
            @(negedge clk);
            check_eq({name, "_after_hold_valid"}, 64'(result_valid_o), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_stall", 64'(stall_req_o), 64'd0);
        check_eq("reset_valid", 64'(result_valid_o), 64'd0);
        check_eq("reset_result", result_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Multiplies
        run_op("mul_7_m3",     OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        run_op("mulhu_ones",   OP_MULHU,  ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op("mulh_ones",    OP_MULH,   ALL1, ALL1, 64'd0, 65, 0);
        run_op("mulhsu_ones",  OP_MULHSU, ALL1, ALL1, ALL1, 65, 0);
        run_op("mulw",         OP_MULW,   64'h0000_0005_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);

        // Divides
        run_op("div_m20_6",    OP_DIV,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op("rem_m20_6",    OP_REM,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op("rem_20_m6",    OP_REM,    64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2, 65, 0);
        run_op("remu_100_7",   OP_REMU,   64'd100, 64'd7, 64'd2, 65, 0);
        run_op("divw",         OP_DIVW,   64'h0000_0001_0000_0007, 64'd2, 64'd3, 33, 0);
        run_op("remw_m7_2",    OP_REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, ALL1, 33, 0);
        run_op("divuw",        OP_DIVUW,  64'hABCD_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 0);

        // Special cases finish at T+1
        run_op("divu_by_zero", OP_DIVU,   64'd5, 64'd0, ALL1, 1, 0);
        run_op("rem_ovf",      OP_REM,    MINN, ALL1, 64'd0, 1, 0);
        run_op("div_ovf",      OP_DIV,    MINN, ALL1, MINN, 1, 0);
        run_op("remuw_zero",   OP_REMUW,  64'h1234_0000_8000_0009, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0009, 1, 0);
        run_op("divw_ovf",     OP_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1, 0);

        // Flush mid-divide at T+10, then a MUL issued at T+11
        op_i = OP_DIV; src1_i = 64'd100; src2_i = 64'd7; valid_i = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_stall", 64'(stall_req_o), 64'd0);
        check_eq("flush_valid", 64'(result_valid_o), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        run_op("mul_after_flush", OP_MUL, 64'd3, 64'd4, 64'd12, 65, 0);

        // Hold for 3 cycles in DONE
        run_op("divu_hold", OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 3);

        // Reset during BUSY
        op_i = OP_MUL; src1_i = 64'd5; src2_i = 64'd9; valid_i = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        valid_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("midreset_stall", 64'(stall_req_o), 64'd0);
        check_eq("midreset_valid", 64'(result_valid_o), 64'd0);
        check_eq("midreset_result", result_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("mulhu_after_reset", OP_MULHU, 64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000,
               64'd3, 65, 0);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
